// File: rtl/morse_letter_scheduler_pkg.sv
// Shared types and constants for the Morse letter scheduler front-end.
package morse_pkg;

  typedef logic [2:0] letter_t;

  localparam letter_t LETTER_A = 3'b000;
  localparam letter_t LETTER_B = 3'b001;
  localparam letter_t LETTER_C = 3'b010;
  localparam letter_t LETTER_D = 3'b011;
  localparam letter_t LETTER_E = 3'b100;
  localparam letter_t LETTER_F = 3'b101;
  localparam letter_t LETTER_G = 3'b110;
  localparam letter_t LETTER_H = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam int unsigned DEFAULT_SYMBOL_LEN = 12;
  localparam int unsigned DEFAULT_GAP_LEN    = 3;

  // Counter width that still holds the value n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/morse_letter_scheduler_if.sv
// Requester/encoder-facing signal bundle of the Morse letter scheduler.
interface morse_letter_scheduler_if
  import morse_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    ReqValid;
  letter_t       ReqLetter0;
  letter_t       ReqLetter1;
  logic [1:0]    ReqReady;
  logic          Flush;
  letter_t       LetterOut;
  logic          StartOut;
  logic          Sending;
  logic          Busy;
  logic [CW-1:0] FifoCount;

  modport master (
    output ReqValid, ReqLetter0, ReqLetter1, Flush,
    input  ReqReady, LetterOut, StartOut, Sending, Busy, FifoCount
  );

  modport slave (
    input  ReqValid, ReqLetter0, ReqLetter1, Flush,
    output ReqReady, LetterOut, StartOut, Sending, Busy, FifoCount
  );

endinterface

// File: rtl/morse_letter_scheduler_fifo.sv
// Small synchronous letter FIFO with same-cycle push/pop and synchronous clear.
module morse_letter_fifo
  import morse_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  letter_t                din,
  output letter_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  letter_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/morse_letter_scheduler.sv
// Round-robin letter intake, buffering and symbol/gap sequencing for the Morse encoder.
module morse_letter_scheduler
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 250,
  parameter int unsigned SYMBOL_LEN = DEFAULT_SYMBOL_LEN,
  parameter int unsigned GAP_LEN    = DEFAULT_GAP_LEN,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    ClockIn,
  input  logic                    Reset,
  morse_letter_scheduler_if.slave bus
);
  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ELEM_MAX = (SYMBOL_LEN > GAP_LEN) ? SYMBOL_LEN : GAP_LEN;
  localparam int unsigned TW       = cnt_width(TICK_DIV);
  localparam int unsigned EW       = cnt_width(ELEM_MAX);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [EW-1:0] SYM_LAST  = EW'(SYMBOL_LEN - 1);
  localparam logic [EW-1:0] GAP_LAST  = EW'(GAP_LEN - 1);

  state_t        state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [EW-1:0] elem, elem_n;
  letter_t       letter, letter_n;
  logic          start, start_n;
  logic          rr;
  logic [1:0]    grant;
  logic [1:0]    ready;
  logic          push;
  logic          pop;
  letter_t       push_letter;
  letter_t       head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          tick_wrap;

  // Arbiter: rr names the favoured requester when both are valid.
  always_comb begin
    grant[0] = bus.ReqValid[0] & (~bus.ReqValid[1] | ~rr);
    grant[1] = bus.ReqValid[1] & (~bus.ReqValid[0] | rr);
    ready    = grant & {2{~full & ~bus.Flush & ~Reset}};
  end

  assign push        = |ready;
  assign push_letter = ready[1] ? bus.ReqLetter1 : bus.ReqLetter0;

  // The pointer only moves on an accepted push, so a stall on a full FIFO keeps the turn order.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      rr <= 1'b0;
    end else if (push) begin
      rr <= ready[0];
    end
  end

  morse_letter_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ClockIn),
    .rst   (Reset),
    .clear (bus.Flush),
    .push  (push),
    .pop   (pop),
    .din   (push_letter),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state  <= IDLE;
      tick   <= '0;
      elem   <= '0;
      letter <= LETTER_A;
      start  <= 1'b0;
    end else begin
      state  <= state_n;
      tick   <= tick_n;
      elem   <= elem_n;
      letter <= letter_n;
      start  <= start_n;
    end
  end

  assign tick_wrap = (tick == TICK_LAST);

  always_comb begin
    state_n  = state;
    tick_n   = tick;
    elem_n   = elem;
    letter_n = letter;
    start_n  = 1'b0;
    pop      = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          letter_n = head;
          start_n  = 1'b1;
          tick_n   = '0;
          elem_n   = '0;
          state_n  = SEND;
        end
      end
      SEND, GAP: begin
        if (tick_wrap) begin
          tick_n = '0;
          elem_n = elem + EW'(1);
        end else begin
          tick_n = tick + TW'(1);
        end
        if (tick_wrap && state == SEND && elem == SYM_LAST) begin
          elem_n  = '0;
          state_n = GAP;
        end else if (tick_wrap && state == GAP && elem == GAP_LAST) begin
          elem_n  = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Flush aborts the letter in flight but leaves the last code on the encoder bus.
    if (bus.Flush) begin
      state_n  = IDLE;
      tick_n   = '0;
      elem_n   = '0;
      letter_n = letter;
      start_n  = 1'b0;
      pop      = 1'b0;
    end
  end

  assign bus.ReqReady  = ready;
  assign bus.LetterOut = letter;
  assign bus.StartOut  = start;
  assign bus.Sending   = (state == SEND);
  assign bus.Busy      = (state != IDLE) | ~empty;
  assign bus.FifoCount = count;

endmodule
